// File: rtl/fetch_pc_predictor_pkg.sv
// Shared types and constants for the fetch-stage PC predictor.
// Holds the counter encodings, the default reset PC, field widths and the training payload.
package fetch_pc_predictor_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned DEFAULT_BTB_ENTRIES = 16;
  localparam int unsigned DEFAULT_INDEX_BITS  = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // 2-bit saturating branch-direction counter
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // One resolved branch from execute, used to train the BTB
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } btb_train_t;

  function automatic int unsigned tag_bits(input int unsigned index_bits);
    return XLEN - index_bits - 2;
  endfunction

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_predictor_if.sv
// Fetch-stage control/branch-resolution bundle between the pipeline and the PC predictor.
interface fetch_pc_predictor_if;
  import fetch_pc_predictor_pkg::*;

  logic            StallF;
  logic            MCycleBusy;
  logic            RedirectE;
  logic [XLEN-1:0] CorrectPCE;
  logic            BranchE;
  logic            TakenE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] BTAE;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            PredictedTakenF;
  logic [XLEN-1:0] PredictedBTAF;

  modport master (
    output StallF, MCycleBusy, RedirectE, CorrectPCE, BranchE, TakenE, PCE, BTAE,
    input  PCF, PCPlus4F, PredictedTakenF, PredictedBTAF
  );

  modport slave (
    input  StallF, MCycleBusy, RedirectE, CorrectPCE, BranchE, TakenE, PCE, BTAE,
    output PCF, PCPlus4F, PredictedTakenF, PredictedBTAF
  );

endinterface

// File: rtl/fetch_pc_predictor_btb_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with one combinational
// read port and one synchronous training port. Reads see pre-update contents.
module fetch_pc_predictor_btb_table
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = DEFAULT_BTB_ENTRIES,
  parameter int unsigned INDEX_BITS  = DEFAULT_INDEX_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            train_en,
  input  btb_train_t      train,
  output logic            hit_c,
  output logic [XLEN-1:0] target_c,
  output ctr_e            ctr_c
);

  localparam int unsigned TAG_BITS = tag_bits(INDEX_BITS);

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  logic            valid_q  [BTB_ENTRIES];
  logic            valid_d  [BTB_ENTRIES];
  tag_t            tag_q    [BTB_ENTRIES];
  tag_t            tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  logic [XLEN-1:0] target_d [BTB_ENTRIES];
  ctr_e            ctr_q    [BTB_ENTRIES];
  ctr_e            ctr_d    [BTB_ENTRIES];

  idx_t rd_idx;
  tag_t rd_tag;
  idx_t wr_idx;
  tag_t wr_tag;
  logic wr_hit;
  logic unused_lsbs;

  // Word-offset bits never take part in index or tag
  assign unused_lsbs = ^{lookup_pc[1:0], train.pc[1:0]};

  assign rd_idx   = lookup_pc[INDEX_BITS+1:2];
  assign rd_tag   = lookup_pc[XLEN-1:INDEX_BITS+2];
  assign hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign target_c = target_q[rd_idx];
  assign ctr_c    = ctr_q[rd_idx];

  assign wr_idx = train.pc[INDEX_BITS+1:2];
  assign wr_tag = train.pc[XLEN-1:INDEX_BITS+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Training: hits move the counter, taken misses allocate weakly-taken
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (train_en) begin
      if (wr_hit) begin
        if (train.taken) begin
          ctr_d[wr_idx]    = ctr_inc(ctr_q[wr_idx]);
          target_d[wr_idx] = train.target;
        end else begin
          ctr_d[wr_idx] = ctr_dec(ctr_q[wr_idx]);
        end
      end else if (train.taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = train.target;
        ctr_d[wr_idx]    = WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage front end: PC register, next-PC priority mux and +4 adder around
// a direct-mapped BTB that predicts taken branches with zero-cycle lookup.
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned     BTB_ENTRIES = DEFAULT_BTB_ENTRIES,
  parameter int unsigned     INDEX_BITS  = DEFAULT_INDEX_BITS,
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  fetch_pc_predictor_if.slave  bus
);

  logic [XLEN-1:0] pcf_q;
  logic [XLEN-1:0] pcf_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pred_bta;
  logic [XLEN-1:0] btb_target;
  logic            btb_hit;
  ctr_e            btb_ctr;
  logic            pred_taken;
  logic            train_en;
  btb_train_t      train;

  assign pc_plus4   = pcf_q + XLEN'(4);
  assign pred_taken = btb_hit && (btb_ctr inside {WT, ST});
  assign pred_bta   = btb_hit ? btb_target : pc_plus4;

  // A busy multi-cycle unit freezes execute, so its branch result is not consumed yet
  assign train_en = bus.BranchE && !bus.MCycleBusy;
  assign train    = '{pc: bus.PCE, target: bus.BTAE, taken: bus.TakenE};

  fetch_pc_predictor_btb_table #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .INDEX_BITS  (INDEX_BITS)
  ) u_btb_table (
    .clk       (CLK),
    .rst_n     (RESETn),
    .lookup_pc (pcf_q),
    .train_en  (train_en),
    .train     (train),
    .hit_c     (btb_hit),
    .target_c  (btb_target),
    .ctr_c     (btb_ctr)
  );

  // Next PC: busy > redirect > stall > predicted target > sequential
  always_comb begin
    pcf_d = pcf_q;
    if (!bus.MCycleBusy) begin
      if (bus.RedirectE) begin
        pcf_d = bus.CorrectPCE;
      end else if (!bus.StallF) begin
        pcf_d = pred_taken ? pred_bta : pc_plus4;
      end
    end
    pcf_d[1:0] = 2'b00;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pcf_q <= RESET_PC;
    end else begin
      pcf_q <= pcf_d;
    end
  end

  assign bus.PCF             = pcf_q;
  assign bus.PCPlus4F        = pc_plus4;
  assign bus.PredictedTakenF = pred_taken;
  assign bus.PredictedBTAF   = pred_bta;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed scenarios followed by random traffic, each
// cycle compared against an entry-table model of the predictor.
module tb_fetch_pc_predictor;

  logic CLK;
  logic RESETn;
  int   checks   = 0;
  int   failures = 0;

  fetch_pc_predictor_if bus_if ();

  fetch_pc_predictor #(
    .BTB_ENTRIES (16),
    .INDEX_BITS  (4),
    .RESET_PC    (32'h0)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: 16 entries, index = (pc/4) mod 16, tag = pc/64, counter 0..3
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;

  task automatic m_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / 64);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare lookup outputs with the model, advance model on the edge
  task automatic cycle(input bit busy, input bit redir, input logic [31:0] cpc, input bit stall,
                       input bit br, input bit tk, input logic [31:0] pce, input logic [31:0] bta);
    logic [31:0] pc4, exp_bta, nxt;
    bit          hit, ptk;
    int          i, t;
    bus_if.MCycleBusy = busy;
    bus_if.RedirectE  = redir;
    bus_if.CorrectPCE = cpc;
    bus_if.StallF     = stall;
    bus_if.BranchE    = br;
    bus_if.TakenE     = tk;
    bus_if.PCE        = pce;
    bus_if.BTAE       = bta;
    #1;
    pc4     = m_pc + 32'd4;
    i       = m_idx(m_pc);
    hit     = m_hit(m_pc);
    ptk     = hit && (m_ctr[i] >= 2);
    exp_bta = hit ? m_tgt[i] : pc4;
    check("PCF", bus_if.PCF, m_pc);
    check("PCPlus4F", bus_if.PCPlus4F, pc4);
    check("PredictedTakenF", {31'b0, bus_if.PredictedTakenF}, {31'b0, ptk});
    check("PredictedBTAF", bus_if.PredictedBTAF, exp_bta);
    if (busy)       nxt = m_pc;
    else if (redir) nxt = cpc;
    else if (stall) nxt = m_pc;
    else if (ptk)   nxt = exp_bta;
    else            nxt = pc4;
    nxt = nxt & ~32'd3;
    if (br && !busy) begin
      t = m_idx(pce);
      if (m_hit(pce)) begin
        if (tk) begin
          m_ctr[t] = (m_ctr[t] == 3) ? 3 : m_ctr[t] + 1;
          m_tgt[t] = bta;
        end else begin
          m_ctr[t] = (m_ctr[t] == 0) ? 0 : m_ctr[t] - 1;
        end
      end else if (tk) begin
        m_valid[t] = 1'b1;
        m_tag[t]   = pce / 64;
        m_tgt[t]   = bta;
        m_ctr[t]   = 2;
      end
    end
    @(posedge CLK);
    #1;
    m_pc = nxt;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic goto(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pce, input bit tk, input logic [31:0] bta);
    cycle(0, 0, 32'h0, 0, 1, tk, pce, bta);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETn = 1'b0;
    bus_if.StallF = 0; bus_if.MCycleBusy = 0; bus_if.RedirectE = 0; bus_if.CorrectPCE = 0;
    bus_if.BranchE = 0; bus_if.TakenE = 0; bus_if.PCE = 0; bus_if.BTAE = 0;
    m_reset();
    #12;
    check("rst_pcf", bus_if.PCF, 32'h0);
    check("rst_pred_taken", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    check("rst_bta", bus_if.PredictedBTAF, 32'h4);
    check("rst_plus4", bus_if.PCPlus4F, 32'h4);
    RESETn = 1'b1;

    // Sequential fetch 0,4,8,C then 0x10
    repeat (4) idle();
    check("seq_pcf", bus_if.PCF, 32'h10);

    // Allocate 0x10 -> 0x40; same-cycle lookup still misses
    train(32'h10, 1, 32'h40);
    check("no_bypass_pcf", bus_if.PCF, 32'h14);
    goto(32'h10);
    check("alloc_pred_taken", {31'b0, bus_if.PredictedTakenF}, 32'h1);
    check("alloc_bta", bus_if.PredictedBTAF, 32'h40);
    idle();
    check("follow_pred_pcf", bus_if.PCF, 32'h40);

    // Two not-taken: 10 -> 01 -> 00
    train(32'h10, 0, 32'h0);
    train(32'h10, 0, 32'h0);
    goto(32'h10);
    check("nt_pred_taken", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    check("nt_bta_hit", bus_if.PredictedBTAF, 32'h40);

    // Four taken saturate at 11; one not-taken still predicts taken, two do not
    repeat (4) train(32'h10, 1, 32'h40);
    goto(32'h10);
    check("sat_pred_taken", {31'b0, bus_if.PredictedTakenF}, 32'h1);
    train(32'h10, 0, 32'h0);
    goto(32'h10);
    check("sat_dec1", {31'b0, bus_if.PredictedTakenF}, 32'h1);
    train(32'h10, 0, 32'h0);
    goto(32'h10);
    check("sat_dec2", {31'b0, bus_if.PredictedTakenF}, 32'h0);

    // Redirect beats stall; busy freezes PC and training
    cycle(0, 1, 32'h80, 1, 0, 0, 32'h0, 32'h0);
    check("redir_over_stall", bus_if.PCF, 32'h80);
    cycle(1, 1, 32'h100, 1, 1, 1, 32'h20, 32'h60);
    check("busy_hold", bus_if.PCF, 32'h80);
    goto(32'h20);
    check("busy_no_train", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    check("busy_no_train_bta", bus_if.PredictedBTAF, 32'h24);

    // Conflict on index 4: 0x50 replaces 0x10
    train(32'h10, 1, 32'h40);
    train(32'h50, 1, 32'h90);
    goto(32'h10);
    check("evict_miss", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    check("evict_bta", bus_if.PredictedBTAF, 32'h14);
    goto(32'h50);
    check("replace_hit", {31'b0, bus_if.PredictedTakenF}, 32'h1);
    check("replace_bta", bus_if.PredictedBTAF, 32'h90);

    // Misaligned redirect near the top of memory, then wrap
    goto(32'hFFFF_FFFE);
    check("align_pcf", bus_if.PCF, 32'hFFFF_FFFC);
    check("wrap_plus4", bus_if.PCPlus4F, 32'h0);
    idle();
    check("wrap_pcf", bus_if.PCF, 32'h0);

    // Random traffic over a small address window so entries alias and hit
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 32'($urandom_range(0, 511)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 127)) << 2, 32'($urandom_range(0, 4095)));
    end

    // Asynchronous reset mid-run
    #3;
    RESETn = 1'b0;
    #1;
    m_reset();
    check("async_rst_pcf", bus_if.PCF, 32'h0);
    check("async_rst_pred", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    check("async_rst_bta", bus_if.PredictedBTAF, 32'h4);
    #2;
    RESETn = 1'b1;
    for (int a = 0; a < 128; a++) begin
      goto(32'(a) << 2);
      check("rst_invalid", {31'b0, bus_if.PredictedTakenF}, 32'h0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
